// File: rtl/alu_pipe_acc_if.sv
// alu_pipe_acc_if: operand/result bus for alu_pipe_acc.
//   master : operand sequencer / result consumer side (drives operands, out_ready)
//   slave  : ALU side (drives in_ready, result and flags)
// Signals: in_valid/in_ready operand handshake; a, b, alu_select, use_acc,
//   acc_clear operand bundle and control; out_valid/out_ready result handshake;
//   alu_output, alu_carry_out, flag_zero, flag_neg, flag_ovf result and status.
interface alu_pipe_acc_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SEL_W-1:0] alu_select;
  logic             use_acc;
  logic             acc_clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_output;
  logic             alu_carry_out;
  logic             flag_zero;
  logic             flag_neg;
  logic             flag_ovf;

  modport master (
    output in_valid, a, b, alu_select, use_acc, acc_clear, out_ready,
    input  in_ready, out_valid, alu_output, alu_carry_out,
           flag_zero, flag_neg, flag_ovf
  );

  modport slave (
    input  in_valid, a, b, alu_select, use_acc, acc_clear, out_ready,
    output in_ready, out_valid, alu_output, alu_carry_out,
           flag_zero, flag_neg, flag_ovf
  );
endinterface

// File: rtl/alu_pipe_acc.sv
// alu_pipe_acc: two-stage pipelined ALU with accumulator operand source,
// status flags and valid/ready flow control.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_pipe_acc_if.slave (operand bundle in, result + flags out)
// Ops: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 ADDC, 6 PASS b, 7 NOT a.
// Optional: define ALU_SATURATE_EN to clamp ADD/ADDC to all-ones on carry
// and SUB to zero on borrow (carry/ovf still report the raw condition).
module alu_pipe_acc #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_pipe_acc_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_ADDC = 3'd5,
    OP_PASS = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  // stage 1
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [SEL_W-1:0] s1_sel;
  logic             s1_use_acc;

  // stage 2 / architectural state
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_out_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;
  logic [WIDTH-1:0] acc;
  logic             carry_q;

  logic             advance;
  logic             in_fire;

  // compute
  op_e              op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   sum_abc;
  logic [WIDTH:0]   diff_ab;
  logic [WIDTH-1:0] res_raw;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid || advance;
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_comb begin
    op      = op_e'(s1_sel);
    // accumulator is sampled here, at stage-2 compute, so a dependent op
    // directly behind its producer already sees the new value
    opa     = s1_use_acc ? acc : s1_a;
    sum_ab  = {1'b0, opa} + {1'b0, s1_b};
    sum_abc = sum_ab + {{WIDTH{1'b0}}, carry_q};
    diff_ab = {1'b0, opa} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};
    res_raw = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (op)
      OP_AND:  res_raw = opa & s1_b;
      OP_OR:   res_raw = opa | s1_b;
      OP_XOR:  res_raw = opa ^ s1_b;
      OP_ADD: begin
        {carry, res_raw} = sum_ab;
        ovf = (opa[MSB] == s1_b[MSB]) && (res_raw[MSB] != opa[MSB]);
      end
      OP_SUB: begin
        {carry, res_raw} = diff_ab;
        ovf = (opa[MSB] != s1_b[MSB]) && (res_raw[MSB] != opa[MSB]);
      end
      OP_ADDC: begin
        {carry, res_raw} = sum_abc;
        ovf = (opa[MSB] == s1_b[MSB]) && (res_raw[MSB] != opa[MSB]);
      end
      OP_PASS: res_raw = s1_b;
      OP_NOT:  res_raw = ~opa;
      default: res_raw = '0;
    endcase
    res = res_raw;
`ifdef ALU_SATURATE_EN
    if ((op == OP_ADD || op == OP_ADDC) && carry) res = '1;
    if (op == OP_SUB && !carry)                   res = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_sel     <= '0;
      s1_use_acc <= 1'b0;
    end else if (in_fire) begin
      s1_valid   <= 1'b1;
      s1_a       <= bus.a;
      s1_b       <= bus.b;
      s1_sel     <= bus.alu_select;
      s1_use_acc <= bus.use_acc;
    end else if (advance) begin
      s1_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      acc         <= '0;
      carry_q     <= 1'b0;
    end else begin
      if (advance) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          out_q       <= res;
          carry_out_q <= carry;
          zero_q      <= (res == '0);
          neg_q       <= res[MSB];
          ovf_q       <= ovf;
          acc         <= res;
          carry_q     <= carry;
        end
      end
      // later assignment wins: clear overrides a same-edge result write
      if (bus.acc_clear) begin
        acc     <= '0;
        carry_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.alu_output    = out_q;
  assign bus.alu_carry_out = carry_out_q;
  assign bus.flag_zero     = zero_q;
  assign bus.flag_neg      = neg_q;
  assign bus.flag_ovf      = ovf_q;

endmodule

// File: tb/tb_alu_pipe_acc.sv
// tb_alu_pipe_acc: scoreboard bench for alu_pipe_acc. Stimulus pushes the
// model's expected result on acceptance; a monitor compares the queue head
// against the DUT whenever out_valid is high and pops on out_ready.
module tb_alu_pipe_acc;
  localparam int W   = 4;
  localparam int SW  = 3;
  localparam int MOD = 1 << W;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_acc_if #(.WIDTH(W), .SEL_W(SW)) bus ();
  alu_pipe_acc #(.WIDTH(W), .SEL_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_m  = 0;
  int   c_m    = 0;
  int   rdy_mode = 1;   // 0: stall, 1: always ready, 2: random

  // reference: plain integer arithmetic on unsigned/signed interpretations
  function automatic exp_t model(int op, int a, int b, bit ua);
    int x, r, sx, sy, sr;
    bit c, v;
    exp_t e;
    x  = ua ? acc_m : a;
    sx = (x >= MOD / 2) ? x - MOD : x;
    sy = (b >= MOD / 2) ? b - MOD : b;
    c  = 1'b0;
    sr = 0;
    case (op)
      0: r = x & b;
      1: r = x | b;
      2: r = x ^ b;
      3: begin r = x + b;        c = (r >= MOD); sr = sx + sy;        end
      4: begin r = x - b;        c = (r >= 0);   sr = sx - sy;        end
      5: begin r = x + b + c_m;  c = (r >= MOD); sr = sx + sy + c_m;  end
      6: r = b;
      default: r = ~x;
    endcase
    v = (op >= 3 && op <= 5) && (sr > MOD / 2 - 1 || sr < -(MOD / 2));
    r = r & (MOD - 1);
`ifdef ALU_SATURATE_EN
    if ((op == 3 || op == 5) && c) r = MOD - 1;
    if (op == 4 && !c)             r = 0;
`endif
    e.res = r[W-1:0];
    e.c   = c;
    e.z   = (r == 0);
    e.n   = (r >= MOD / 2);
    e.v   = v;
    acc_m = r;
    c_m   = c ? 1 : 0;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(3) != 0);
    endcase
  end

  // monitor: compare head while valid (including stalled cycles), pop on transfer
  always @(negedge clk) begin : monitor
    exp_t e, got;
    if (rst_n && bus.out_valid) begin
      got = {bus.alu_output, bus.alu_carry_out, bus.flag_zero, bus.flag_neg, bus.flag_ovf};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got res=%h c=%b z=%b n=%b v=%b",
                 got.res, got.c, got.z, got.n, got.v);
      end else begin
        e = sb_q[0];
        if (got !== e) begin
          errors++;
          $display("FAIL result got res=%h c=%b z=%b n=%b v=%b want res=%h c=%b z=%b n=%b v=%b",
                   got.res, got.c, got.z, got.n, got.v, e.res, e.c, e.z, e.n, e.v);
        end
        if (bus.out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(int op, int a, int b, bit ua);
    int budget;
    bit fire, done;
    budget = 200;
    done   = 1'b0;
    bus.in_valid   = 1'b1;
    bus.alu_select = op[SW-1:0];
    bus.a          = a[W-1:0];
    bus.b          = b[W-1:0];
    bus.use_acc    = ua;
    while (!done && budget > 0) begin
      @(negedge clk);
      fire = bus.in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        sb_q.push_back(model(op, a, b, ua));
        done = 1'b1;
      end
      budget--;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=not_accepted want=accepted");
    end
  endtask

  task automatic drain();
    int budget;
    budget = 2000;
    while (sb_q.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d pending want=0", sb_q.size());
    end
    idle(2);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int accepted, k;
    bit fire;
    int bp_a[4], bp_b[4], bp_op[4];

    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.alu_select = '0;
    bus.use_acc    = 1'b0;
    bus.acc_clear  = 1'b0;
    rdy_mode       = 1;
    idle(3);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_alu_output", bus.alu_output, 0);
    chk("reset_flags", {bus.alu_carry_out, bus.flag_zero, bus.flag_neg, bus.flag_ovf}, 0);
    rst_n = 1'b1;
    idle(2);

    // directed vectors
    send(0, 15, 15, 0);
    send(3, 15, 15, 0);
    send(4, 0, 1, 0);
    send(4, 5, 5, 0);
    send(6, 0, 3, 0);
    send(3, 0, 5, 1);     // acc 3 + 5 -> 8, signed overflow
    send(3, 15, 1, 0);    // carry out
    send(5, 1, 1, 0);     // 1 + 1 + stored carry
    send(7, 10, 0, 0);
    drain();

    // clear with pipeline idle
    bus.acc_clear = 1'b1;
    idle(1);
    bus.acc_clear = 1'b0;
    acc_m = 0;
    c_m   = 0;
    send(3, 0, 1, 1);
    drain();

    // clear on the same edge as a result write: result still emitted, acc cleared
    send(3, 15, 8, 0);    // produces carry too
    bus.acc_clear = 1'b1;
    idle(1);
    bus.acc_clear = 1'b0;
    acc_m = 0;
    c_m   = 0;
    send(5, 0, 2, 1);     // expects 0 + 2 + 0
    drain();

    // back-pressure: stall consumer, keep offering bundles
    rdy_mode = 0;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      bp_op[i] = $urandom_range(7);
      bp_a[i]  = $urandom_range(MOD - 1);
      bp_b[i]  = $urandom_range(MOD - 1);
    end
    accepted = 0;
    k = 0;
    repeat (4) begin
      bus.in_valid   = 1'b1;
      bus.alu_select = bp_op[k][SW-1:0];
      bus.a          = bp_a[k][W-1:0];
      bus.b          = bp_b[k][W-1:0];
      bus.use_acc    = 1'b0;
      @(negedge clk);
      fire = bus.in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        sb_q.push_back(model(bp_op[k], bp_a[k], bp_b[k], 1'b0));
        accepted++;
        k++;
      end
    end
    @(negedge clk);
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_accepted", accepted, 2);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rdy_mode = 1;
    for (int i = k; i < 4; i++) send(bp_op[i], bp_a[i], bp_b[i], 1'b0);
    drain();

    // randomized traffic with random consumer stalls
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      send($urandom_range(7), $urandom_range(MOD - 1), $urandom_range(MOD - 1),
           bit'($urandom_range(1)));
      if ($urandom_range(7) == 0) idle($urandom_range(3));
    end
    rdy_mode = 1;
    drain();

    // async reset with two ops in flight
    send(6, 0, 9, 0);
    send(3, 0, 4, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", bus.out_valid, 0);
    chk("midreset_alu_output", bus.alu_output, 0);
    chk("midreset_flags", {bus.alu_carry_out, bus.flag_zero, bus.flag_neg, bus.flag_ovf}, 0);
    sb_q.delete();
    acc_m = 0;
    c_m   = 0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(3, 0, 5, 1);     // accumulator must read 0 after reset
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
